rr_mux8_arbiter: RTL and testbench
==================================

# rr_mux8_arbiter

Round-robin arbiter and sequencer for the 8-to-1 single-bit selector datapath. Up to 8 requesters each present a request line and a data bit. The block grants exactly one requester at a time, drives the 3-bit select, and routes the granted requester's bit to a single output. Grants are held for a bounded burst so that no requester can starve the others.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant is held. Legal range 1..15.
- `CNT_W`, default 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 8: request line per requester, sampled on `clk`.
- `din` input 8: data bit per requester.
- `grant` output 8: one-hot registered grant; all zeros when idle.
- `sel` output 3: registered select; the index of the granted requester.
- `valid` output 1: high while a grant is active.
- `dout` output 1: `din[sel]` when `valid`, else 0. Combinational from `din`.
- `hold_cnt` output CNT_W: cycles the current grant has been active, 1-based.

## Operation
- The block has two states: IDLE and GRANT.
- Round-robin pointer `ptr` (3 bits): the index with the highest priority. The search runs `ptr`, `ptr+1`, … `ptr+7`, mod 8.
- **IDLE**
  - If `req` is nonzero, pick the winner from `ptr` and go to GRANT.
  - On that transition: `sel`=winner, `grant`=1<<winner, `hold_cnt`=1.
  - Otherwise stay in IDLE.
- **GRANT, continue:** if `req[sel]`=1 and `hold_cnt` < MAX_HOLD, hold the grant and increment `hold_cnt`.
- **GRANT, release:** release when `req[sel]`=0 or `hold_cnt`=MAX_HOLD.
  - `ptr` is set to `sel+1` (wraps 7→0).
  - Arbitrate the current `req` from the new pointer. If there is a winner, move to GRANT for it with `hold_cnt`=1, with no idle bubble. Otherwise go to IDLE.
  - A lone requester that hits MAX_HOLD is re-granted immediately, and `hold_cnt` restarts at 1.
- **Other rules**
  - `grant`, `sel` and `valid` are mutually consistent every cycle.
  - `dout` never reflects a non-granted requester.
  - The `din` bits of requesters without a grant are ignored.
  - Dropping a request while another requester holds the grant has no effect.
- **Reset:** asserting `rst_n` low at any time, including mid-burst, immediately sets:
  - state=IDLE, `grant`=0, `sel`=0, `valid`=0, `hold_cnt`=0, `ptr`=0.
  - `dout`=0, because `valid` is 0.

## Timing
- Request-to-grant latency: 1 cycle. `req` is sampled at edge k; `grant` and `valid` are visible after edge k.
- `dout` follows `din[sel]` combinationally in the same cycle. There is no added latency.
- Release and re-grant happen on the same edge. `valid` stays continuously high across a handover when other requests are pending.
- Maximum wait for any continuously asserted request is 7×MAX_HOLD + 1 cycles.
- After reset deassertion, the first grant is given on the first edge where `req`≠0. Priority starts at requester 0.

## Structure
- The shared package `mux_pkg` holds:
  - `NUM_REQ`=8 and `SEL_W`=3.
  - The state encoding constants IDLE=1'b0 and GRANT=1'b1.
- One natural sub-module: `rr_pick8`, a combinational priority search.
  - Inputs: `req`[7:0] and `ptr`[2:0].
  - Outputs: `found` and `idx`[2:0].
  - It is instantiated once and reused for both the IDLE and the release arbitration.
- The output path reuses the team's existing 8-to-1 mux, driven by `sel` and gated by `valid`.

## Test plan
- **Reset and idle:** after reset, `req`=0 for 5 cycles → `grant`=0, `valid`=0, `sel`=0, `dout`=0, `hold_cnt`=0.
- **Single requester, data path:** `req`=8'b0000_0100 held and `din[2]` toggled each cycle (MAX_HOLD=4).
  - One cycle later: `grant`=8'h04, `sel`=2, and `dout` tracks `din[2]`.
  - `hold_cnt` runs 1,2,3,4, then returns to 1 with no `valid` drop.
- **Round-robin fairness:** `req`=8'hFF held.
  - `sel` sequence is 0,1,2,…,7,0, each grant lasting exactly 4 cycles, with `valid` continuously 1.
- **Early release:** requester 5 is granted, then `req[5]` drops at `hold_cnt`=2 while `req[1]`=1.
  - Next cycle: `sel`=1, `hold_cnt`=1.
  - Later, with only `req[6]` and `req[0]` set, 6 wins because `ptr`=2.
- **Wrap and isolation:** requester 7 is granted and `req`=8'h81; `din`=8'h7F, so every other bit is 1.
  - `dout`=0 while 7 holds the grant.
  - At release, 0 wins (wrap) and `dout`=1.
- **Reset mid-burst:** `rst_n` pulsed low asynchronously at `hold_cnt`=3 on `sel`=4.
  - Outputs clear immediately, with no clock edge needed.
  - After release, with `req`=8'h11: 0 wins first.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the 8-to-1 selector datapath
// and its round-robin arbiter.
package mux_pkg;

   localparam int NUM_REQ = 8;
   localparam int SEL_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/mux8to1.sv
// Existing 8-to-1 single-bit selector, gated so that a disabled path
// always reads as 0.
module mux8to1 (
   input  logic [7:0] d,
   input  logic [2:0] s,
   input  logic       en,
   output logic       y
);

   assign y = en & d[s];

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin priority search.
// Finds the first set request at or after ptr, wrapping modulo 8.
module rr_pick8
   import mux_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);

   logic [SEL_W-1:0] cand;

   // Scan from the farthest offset down to ptr, so the nearest hit lands last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = ptr + SEL_W'(i);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter for eight requesters, with bounded grant bursts.
// The granted requester's data bit is routed to dout through the 8-to-1 mux.
module rr_mux8_arbiter
   import mux_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         req,
   input  logic [7:0]         din,
   output logic [7:0]         grant,
   output logic [2:0]         sel,
   output logic               valid,
   output logic               dout,
   output logic [CNT_W-1:0]   hold_cnt
);

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;
   logic [SEL_W-1:0]   sel_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [SEL_W-1:0]   pick_ptr;
   logic [SEL_W-1:0]   pick_idx;
   logic               pick_found;
   logic               keep;

   // One search serves both cases: from ptr when idle, from sel+1 on release.
   assign pick_ptr = (state == GRANT) ? sel + SEL_W'(1) : ptr;
   assign keep     = req[sel] && (hold_cnt < CNT_W'(MAX_HOLD));
   assign valid    = (state == GRANT);

   rr_pick8 u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   mux8to1 u_mux (
      .d  (din),
      .s  (sel),
      .en (valid),
      .y  (dout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         sel      <= '0;
         hold_cnt <= '0;
         grant    <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         sel      <= sel_nxt;
         hold_cnt <= cnt_nxt;
         grant    <= grant_nxt;
      end
   end

   // Release and re-grant share one edge, so valid has no bubble on handover.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sel_nxt   = sel;
      cnt_nxt   = hold_cnt;
      grant_nxt = grant;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = GRANT;
               sel_nxt   = pick_idx;
               cnt_nxt   = CNT_W'(1);
               grant_nxt = NUM_REQ'(1) << pick_idx;
            end
         end
         GRANT: begin
            if (keep) begin
               cnt_nxt = hold_cnt + CNT_W'(1);
            end else begin
               ptr_nxt = sel + SEL_W'(1);
               if (pick_found) begin
                  sel_nxt   = pick_idx;
                  cnt_nxt   = CNT_W'(1);
                  grant_nxt = NUM_REQ'(1) << pick_idx;
               end else begin
                  state_nxt = IDLE;
                  sel_nxt   = '0;
                  cnt_nxt   = '0;
                  grant_nxt = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            sel_nxt   = '0;
            cnt_nxt   = '0;
            grant_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Self-checking bench for rr_mux8_arbiter: a behavioural round-robin model
// checked every cycle, plus directed scenarios with hand-computed values.
module tb_rr_mux8_arbiter;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic [7:0] din = 8'h00;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       valid;
   logic       dout;
   logic [3:0] hold_cnt;

   int testCount = 0;
   int failCount = 0;
   bit checkEn   = 1'b0;

   // Model state: who owns the grant, for how long, and the priority pointer.
   bit mActive = 1'b0;
   int mOwner  = 0;
   int mCnt    = 0;
   int mPtr    = 0;

   rr_mux8_arbiter #(.MAX_HOLD(MAXH), .CNT_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .din      (din),
      .grant    (grant),
      .sel      (sel),
      .valid    (valid),
      .dout     (dout),
      .hold_cnt (hold_cnt)
   );

   always #5 clk = ~clk;

   function automatic int pickFrom(logic [7:0] r, int p);
      for (int i = 0; i < 8; i++) begin
         if (r[(p + i) % 8]) return (p + i) % 8;
      end
      return -1;
   endfunction

   // Behavioural model of the arbitration rules.
   always @(posedge clk or negedge rst_n) begin
      int w;
      if (!rst_n) begin
         mActive <= 1'b0;
         mOwner  <= 0;
         mCnt    <= 0;
         mPtr    <= 0;
      end else if (!mActive) begin
         w = pickFrom(req, mPtr);
         if (w >= 0) begin
            mActive <= 1'b1;
            mOwner  <= w;
            mCnt    <= 1;
         end
      end else if (req[mOwner] && mCnt < MAXH) begin
         mCnt <= mCnt + 1;
      end else begin
         mPtr <= (mOwner + 1) % 8;
         w = pickFrom(req, (mOwner + 1) % 8);
         if (w >= 0) begin
            mOwner <= w;
            mCnt   <= 1;
         end else begin
            mActive <= 1'b0;
            mOwner  <= 0;
            mCnt    <= 0;
         end
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model.grant", int'(grant), mActive ? (1 << mOwner) : 0);
         checkOutput("model.sel", int'(sel), mActive ? mOwner : 0);
         checkOutput("model.valid", int'(valid), int'(mActive));
         checkOutput("model.hold_cnt", int'(hold_cnt), mCnt);
         checkOutput("model.dout", int'(dout), mActive ? int'(din[mOwner]) : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d);
      req = r;
      din = d;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      applyStimulus(8'h00, 8'h00);
      tick();
      tick();
      rst_n   = 1'b1;
      checkEn = 1'b1;

      // Reset and idle
      for (int i = 0; i < 5; i++) tick();
      checkOutput("idle.grant", int'(grant), 0);
      checkOutput("idle.valid", int'(valid), 0);
      checkOutput("idle.sel", int'(sel), 0);
      checkOutput("idle.dout", int'(dout), 0);
      checkOutput("idle.hold_cnt", int'(hold_cnt), 0);

      // Single requester with toggling data
      applyStimulus(8'h04, 8'h00);
      tick();
      checkOutput("single.grant", int'(grant), 8'h04);
      checkOutput("single.sel", int'(sel), 2);
      checkOutput("single.hold1", int'(hold_cnt), 1);
      for (int k = 2; k <= 5; k++) begin
         din[2] = ~din[2];
         tick();
         checkOutput("single.hold", int'(hold_cnt), (k == 5) ? 1 : k);
         checkOutput("single.valid", int'(valid), 1);
         checkOutput("single.dout", int'(dout), int'(din[2]));
      end
      applyStimulus(8'h00, 8'h00);
      tick();
      checkOutput("single.release", int'(valid), 0);

      // Round-robin fairness from a fresh pointer
      doReset();
      applyStimulus(8'hFF, 8'hA5);
      tick();
      for (int t = 0; t < 36; t++) begin
         checkOutput("rr.sel", int'(sel), (t / 4) % 8);
         checkOutput("rr.valid", int'(valid), 1);
         tick();
      end

      // Early release, then pointer-driven priority
      doReset();
      applyStimulus(8'h20, 8'h00);
      tick();
      checkOutput("early.sel5", int'(sel), 5);
      applyStimulus(8'h22, 8'h00);
      tick();
      checkOutput("early.hold2", int'(hold_cnt), 2);
      applyStimulus(8'h02, 8'h00);
      tick();
      checkOutput("early.sel1", int'(sel), 1);
      checkOutput("early.hold1", int'(hold_cnt), 1);
      applyStimulus(8'h41, 8'h00);
      tick();
      checkOutput("early.sel6", int'(sel), 6);

      // Wrap and isolation of non-granted data
      applyStimulus(8'h80, 8'h00);
      tick();
      checkOutput("wrap.sel7", int'(sel), 7);
      applyStimulus(8'h81, 8'h7F);
      #1;
      checkOutput("wrap.dout0", int'(dout), 0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         checkOutput("wrap.hold", int'(hold_cnt), k);
         checkOutput("wrap.isolate", int'(dout), 0);
      end
      tick();
      checkOutput("wrap.sel0", int'(sel), 0);
      checkOutput("wrap.dout1", int'(dout), 1);

      // Asynchronous reset mid-burst
      doReset();
      applyStimulus(8'h10, 8'hFF);
      tick();
      tick();
      tick();
      checkOutput("rst.sel4", int'(sel), 4);
      checkOutput("rst.hold3", int'(hold_cnt), 3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst.grant", int'(grant), 0);
      checkOutput("rst.valid", int'(valid), 0);
      checkOutput("rst.sel", int'(sel), 0);
      checkOutput("rst.hold", int'(hold_cnt), 0);
      checkOutput("rst.dout", int'(dout), 0);
      rst_n = 1'b1;
      applyStimulus(8'h11, 8'h01);
      tick();
      checkOutput("rst.first", int'(sel), 0);
      checkOutput("rst.grant0", int'(grant), 8'h01);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
